spi_ram_responder: RTL
======================

// Module: spi_ram_responder
// PURPOSE
// - SPI-mode-0 serial-SRAM responder: the device end of the CPU's SPI RAM link, used as a
//   bench/FPGA memory model behind the CPU's spi_mosi/spi_select/spi_clk/spi_miso pins.
// - Decodes READ (0x03) and WRITE (0x02) with an ADDR_BITS big-endian address, then streams
//   bytes with auto-increment. Has a backdoor port for program preload and result inspection.
// PARAMETERS
// - ADDR_BITS   16   address bits shifted after the command byte (multiple of 8)
// - MEM_BYTES   256  backing array size, power of two; address used modulo MEM_BYTES
// PORTS
// - clk        in   1   clock; SPI inputs are synchronous to clk (same domain as the initiator)
// - rst_n      in   1   synchronous, active-low reset
// - spi_cs_n   in   1   chip select, active low
// - spi_sclk   in   1   SPI clock, idle low (mode 0)
// - spi_mosi   in   1   serial data from initiator, MSB first
// - spi_miso   out  1   serial data to initiator, MSB first
// - dbg_addr   in   ADDR_BITS  backdoor byte address (modulo MEM_BYTES)
// - dbg_we     in   1   backdoor write strobe
// - dbg_wdata  in   8   backdoor write data
// - dbg_rdata  out  8   backdoor read data, combinational mem[dbg_addr]
// - active     out  1   high while a command is selected (state != IDLE)
// BEHAVIOUR
// - Edge detect: sclk_q <= spi_sclk each clk; rise = sclk & ~sclk_q, fall = ~sclk & sclk_q.
//   SCLK high/low half-period >= 1 clk.
// - Reset: state=IDLE, spi_miso=0, active=0, bit counter=0, shift regs=0, addr=0; memory NOT cleared.
// - spi_cs_n high in any state: next clk -> IDLE, counters cleared, miso=0. Partial byte discarded.
// - FSM: IDLE -(cs_n low)-> CMD -(8 rises)-> ADDR | IGNORE; ADDR -(ADDR_BITS rises)-> READ | WRITE.
//   CMD:   MOSI sampled on rise into cmd shift reg. After 8th bit: 0x03/0x02 -> ADDR, else -> IGNORE.
//   ADDR:  MOSI sampled on rise, MSB first. Load addr on the clk after the last address bit.
//   READ:  each fall while bit count is 0 loads tx <= mem[addr], presents tx[7]; later falls shift.
//          After 8th fall of a byte, addr <= addr+1. spi_miso is registered and valid 1 clk after
//          the fall, i.e. before the next rise. First data bit follows the fall after last addr bit.
//   WRITE: MOSI sampled on rise. On the clk after the 8th rise: mem[addr] <= rx byte, addr <= addr+1.
//   IGNORE: no memory access; miso held 0 until cs_n high.
// - Address wrap: addr increments modulo MEM_BYTES; MEM_BYTES-1 -> 0 (sequential mode, no page limit).
// - Initiator's 2-byte words = 2 consecutive bytes, big-endian (addr = MSB, addr+1 = LSB).
// - Backdoor: dbg_we writes on clk edge in any state. Same-clk collision with SPI write to the
//   same address: SPI write wins. dbg_rdata reflects writes from the following cycle.
// - CMD/ADDR miso = 0. Read of the byte just written in the same CS window returns new data.
// - Command with cs_n rising mid-address: no access, addr register unchanged for observers.
// CONFIGURATION
// - SPI_RAM_RESP_WP_EN defined: adds input wp_n (1 bit). While wp_n=0 at the byte-commit clk,
//   WRITE data bytes are discarded but addr still increments; READ unaffected; backdoor unaffected.
//   Also adds output wp_hits (8 bits, reset 0, saturating at 255) counting discarded bytes.
// - Undefined: no wp_n/wp_hits ports; every WRITE byte commits.
// TESTING
// - Backdoor preload mem[0x10]=0xA5, mem[0x11]=0x3C; SPI 03 00 10 + 16 clocks -> MISO 0xA5, 0x3C.
// - SPI 02 00 20 AB CD, cs_n high -> dbg_rdata: [0x20]=0xAB, [0x21]=0xCD; active=0 within 1 clk.
// - Write at 0x00FF (MEM_BYTES=256) bytes 11 22 -> mem[0xFF]=0x11, mem[0x00]=0x22 (wrap).
// - Command 0x9F + 40 clocks -> MISO constantly 0, memory unchanged; next 03 command works.
// - WRITE 02 00 30 + 5 data bits then cs_n high -> mem[0x30] unchanged; state IDLE next clk.
// - rst_n low mid-READ -> miso=0, active=0 next clk; earlier preload still readable via dbg.
//   SPI_RAM_RESP_WP_EN builds: wp_n=0 WRITE of 3 bytes -> memory unchanged, wp_hits=3.

Source files
------------

// File: rtl/spi_ram_responder.sv
// spi_ram_responder: SPI mode-0 serial-SRAM device model (READ 0x03 / WRITE 0x02, auto-increment) with backdoor port.
// Optional write protect: define SPI_RAM_RESP_WP_EN to add wp_n input and wp_hits counter.
module spi_ram_responder #(
    parameter int ADDR_BITS = 16,
    parameter int MEM_BYTES = 256
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 spi_cs_n,
    input  logic                 spi_sclk,
    input  logic                 spi_mosi,
    output logic                 spi_miso,
    input  logic [ADDR_BITS-1:0] dbg_addr,
    input  logic                 dbg_we,
    input  logic [7:0]           dbg_wdata,
    output logic [7:0]           dbg_rdata,
`ifdef SPI_RAM_RESP_WP_EN
    input  logic                 wp_n,
    output logic [7:0]           wp_hits,
`endif
    output logic                 active
);
    localparam int AW = $clog2(MEM_BYTES);
    localparam int CW = $clog2(ADDR_BITS + 1);
    typedef enum logic [2:0] {IDLE, CMD, ADDR, READ, WRITE, IGNORE} state_t;
    state_t         state, state_nx;
    logic           sclk_q, rise, fall;
    logic [CW-1:0]  cnt;
    logic [7:0]     cmd_sr, cmd_nx, tx, rx, rx_nx;
    logic [AW-1:0]  addr_sr, addr_nx, addr;
    logic           cmd_last, addr_last, byte_last, wr_pend, spi_we;
    logic [7:0]     mem [MEM_BYTES];
    logic [ADDR_BITS-AW-1:0] unused_dbg_hi;
    assign rise      = spi_sclk & ~sclk_q;
    assign fall      = ~spi_sclk & sclk_q;
    assign cmd_nx    = {cmd_sr[6:0], spi_mosi};
    assign addr_nx   = {addr_sr[AW-2:0], spi_mosi};
    assign rx_nx     = {rx[6:0], spi_mosi};
    assign byte_last = cnt == CW'(7);
    assign cmd_last  = rise && byte_last;
    assign addr_last = rise && cnt == CW'(ADDR_BITS - 1);
    assign spi_miso  = tx[7];
    assign active    = state != IDLE;
    assign dbg_rdata = mem[dbg_addr[AW-1:0]];
    assign unused_dbg_hi = dbg_addr[ADDR_BITS-1:AW];
    // SCLK edge detection against the previous clk sample
    always_ff @(posedge clk) begin
        sclk_q <= rst_n ? spi_sclk : 1'b0;
    end
    // FSM state register
    always_ff @(posedge clk) begin
        state <= rst_n ? state_nx : IDLE;
    end
    // FSM next state: deselect always returns to IDLE
    always_comb begin
        state_nx = state;
        if (spi_cs_n)
            state_nx = IDLE;
        else
            case (state)
                IDLE:    state_nx = CMD;
                CMD:     if (cmd_last) state_nx = (cmd_nx == 8'h03 || cmd_nx == 8'h02) ? ADDR : IGNORE;
                ADDR:    if (addr_last) state_nx = (cmd_sr == 8'h03) ? READ : WRITE;
                default: state_nx = state;
            endcase
    end
    // Shift registers, bit counter, address pointer and write-commit pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt     <= '0;
            cmd_sr  <= '0;
            addr_sr <= '0;
            addr    <= '0;
            tx      <= '0;
            rx      <= '0;
            wr_pend <= 1'b0;
        end else begin
            wr_pend <= 1'b0;
            if (wr_pend)
                addr <= addr + AW'(1);
            if (spi_cs_n) begin
                cnt     <= '0;
                cmd_sr  <= '0;
                addr_sr <= '0;
                tx      <= '0;
                rx      <= '0;
            end else
                case (state)
                    CMD: if (rise) begin
                        cmd_sr <= cmd_nx;
                        cnt    <= cmd_last ? '0 : cnt + CW'(1);
                    end
                    ADDR: if (rise) begin
                        addr_sr <= addr_nx;
                        cnt     <= addr_last ? '0 : cnt + CW'(1);
                        if (addr_last)
                            addr <= addr_nx;
                    end
                    READ: if (fall) begin
                        tx  <= (cnt == '0) ? mem[addr] : {tx[6:0], 1'b0};
                        cnt <= byte_last ? '0 : cnt + CW'(1);
                        if (byte_last)
                            addr <= addr + AW'(1);
                    end
                    WRITE: if (rise) begin
                        rx      <= rx_nx;
                        cnt     <= byte_last ? '0 : cnt + CW'(1);
                        wr_pend <= byte_last;
                    end
                    default: ;
                endcase
        end
    end
`ifdef SPI_RAM_RESP_WP_EN
    assign spi_we = wr_pend & wp_n;
    // Count bytes dropped by write protect, saturating
    always_ff @(posedge clk) begin
        if (!rst_n)
            wp_hits <= '0;
        else if (wr_pend && !wp_n && wp_hits != 8'hFF)
            wp_hits <= wp_hits + 8'd1;
    end
`else
    assign spi_we = wr_pend;
`endif
    // Backing store: SPI commit is written last so it wins a same-address collision
    always_ff @(posedge clk) begin
        if (dbg_we)
            mem[dbg_addr[AW-1:0]] <= dbg_wdata;
        if (spi_we)
            mem[addr] <= rx;
    end
endmodule
